// File: rtl/bist_engine_p.sv
// Logic BIST engine: Fibonacci LFSR patterns, scan sequencer, Galois MISR and golden compare.
// Define BIST_DIAG_EN to add the signature/pat_cnt_o outputs and the bist_abort input.
module bist_engine_p #(
    parameter int                  LFSR_W       = 8,
    parameter logic [LFSR_W-1:0]   LFSR_TAPS    = 8'hB8,
    parameter logic [LFSR_W-1:0]   LFSR_SEED    = 8'h01,
    parameter int                  PI_W         = 3,
    parameter int                  PO_W         = 2,
    parameter int                  MISR_W       = 16,
    parameter logic [MISR_W-1:0]   MISR_POLY    = 16'h1021,
    parameter int                  CHAIN_LEN    = 8,
    parameter int                  NUM_PATTERNS = 32,
    parameter logic [MISR_W-1:0]   GOLDEN       = 16'h0000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            bist_start,
    input  logic [PI_W-1:0] func_pi,
    output logic [PI_W-1:0] cut_pi,
    output logic            scan_en,
    output logic            scan_in,
    input  logic            scan_out,
    input  logic [PO_W-1:0] cut_po,
`ifdef BIST_DIAG_EN
    input  logic                                bist_abort,
    output logic [MISR_W-1:0]                   signature,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]   pat_cnt_o,
`endif
    output logic            test_mode,
    output logic            bist_end,
    output logic            pass_fail
);

    localparam int PAT_CW = $clog2(NUM_PATTERNS + 1);
    localparam int BIT_CW = $clog2(CHAIN_LEN + 1);
    localparam logic [PAT_CW-1:0] PAT_LAST = PAT_CW'(NUM_PATTERNS - 1);
    localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(CHAIN_LEN - 1);
    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE, S_DONE
    } state_t;

    state_t              state, state_nx;
    logic [LFSR_W-1:0]   lfsr;
    logic [MISR_W-1:0]   misr;
    logic [PAT_CW-1:0]   pat_cnt;
    logic [BIT_CW-1:0]   bit_cnt;
    logic [MISR_W-1:0]   comp_in;
    logic                bit_last;
    logic                abort_hit;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                     input logic [MISR_W-1:0] d);
        return {m[MISR_W-2:0], 1'b0} ^ (m[MISR_W-1] ? MISR_POLY : '0) ^ d;
    endfunction

    assign comp_in  = MISR_W'({cut_po, scan_out});
    assign bit_last = (bit_cnt == BIT_LAST);

`ifdef BIST_DIAG_EN
    assign abort_hit = bist_abort &&
                       (state inside {S_SEED, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE});
    assign signature = misr;
    assign pat_cnt_o = pat_cnt;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        scan_en   = 1'b0;
        scan_in   = 1'b0;
        test_mode = 1'b0;
        bist_end  = 1'b0;
        cut_pi    = func_pi;
        case (state)
            S_IDLE: begin
                if (bist_start) state_nx = S_SEED;
            end
            S_SEED: begin
                state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                scan_en   = 1'b1;
                scan_in   = lfsr[0];
                test_mode = 1'b1;
                cut_pi    = lfsr[PI_W-1:0];
                if (bit_last) state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                test_mode = 1'b1;
                cut_pi    = lfsr[PI_W-1:0];
                state_nx  = (pat_cnt == PAT_LAST) ? S_UNLOAD : S_SHIFT;
            end
            S_UNLOAD: begin
                scan_en   = 1'b1;
                test_mode = 1'b1;
                cut_pi    = lfsr[PI_W-1:0];
                if (bit_last) state_nx = S_COMPARE;
            end
            S_COMPARE: begin
                state_nx = S_DONE;
            end
            S_DONE: begin
                bist_end = 1'b1;
                if (bist_start) state_nx = S_SEED;
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort_hit) state_nx = S_DONE;
    end

    // Pattern generation, compaction and verdict; the first chain load is not compacted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr      <= SEED_EFF;
            misr      <= '0;
            pat_cnt   <= '0;
            bit_cnt   <= '0;
            pass_fail <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bist_start) pass_fail <= 1'b0;
                end
                S_SEED: begin
                    lfsr      <= SEED_EFF;
                    misr      <= '0;
                    pat_cnt   <= '0;
                    bit_cnt   <= '0;
                    pass_fail <= 1'b0;
                end
                S_SHIFT: begin
                    lfsr    <= lfsr_step(lfsr);
                    bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
                    if (pat_cnt != '0) misr <= misr_step(misr, comp_in);
                end
                S_CAPTURE: begin
                    misr    <= misr_step(misr, comp_in);
                    pat_cnt <= pat_cnt + 1'b1;
                end
                S_UNLOAD: begin
                    misr    <= misr_step(misr, comp_in);
                    bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
                end
                S_COMPARE: begin
                    pass_fail <= (misr == GOLDEN);
                end
                default: ;
            endcase
            if (abort_hit) pass_fail <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bist_engine_p.sv
// Directed bench for bist_engine_p: CHAIN_LEN=4, NUM_PATTERNS=3, CUT = 4-bit scan register.
module tb_bist_engine_p;

    logic       CLK = 1'b0;
    logic       RST;
    logic       bist_start;
    logic [2:0] func_pi;
    logic [2:0] cut_pi, cut_pi0;
    logic       scan_en, scan_en0, scan_in, scan_in0;
    logic       scan_out;
    logic [1:0] cut_po;
    logic       test_mode, test_mode0, bist_end, bist_end0, pass_fail, pass_fail0;
    logic [3:0] chain;
    logic       stuck;
`ifdef BIST_DIAG_EN
    logic        bist_abort;
    logic [15:0] signature, signature0;
    logic [1:0]  pat_cnt_o, pat_cnt0;
`endif

    int errors = 0;
    int checks = 0;
    // Expected scan_in on SHIFT cycles (cycle n = period after edge n-1, edge 0 samples start).
    int sin_tab [2:20];

    always #5 CLK = ~CLK;

    // CUT: shifts scan_in when scan_en, else captures the parity of its primary inputs.
    always_ff @(posedge CLK) chain <= {chain[2:0], scan_en ? scan_in : ^cut_pi};
    assign scan_out = stuck | chain[3];
    assign cut_po   = cut_pi[1:0];

    bist_engine_p #(.CHAIN_LEN(4), .NUM_PATTERNS(3), .GOLDEN(16'hC7A5)) dut (
        .CLK(CLK), .RST(RST), .bist_start(bist_start), .func_pi(func_pi),
        .cut_pi(cut_pi), .scan_en(scan_en), .scan_in(scan_in),
        .scan_out(scan_out), .cut_po(cut_po),
`ifdef BIST_DIAG_EN
        .bist_abort(bist_abort), .signature(signature), .pat_cnt_o(pat_cnt_o),
`endif
        .test_mode(test_mode), .bist_end(bist_end), .pass_fail(pass_fail)
    );

    bist_engine_p #(.CHAIN_LEN(4), .NUM_PATTERNS(3), .GOLDEN(16'hC7A5),
                    .LFSR_SEED(8'h00)) dut0 (
        .CLK(CLK), .RST(RST), .bist_start(bist_start), .func_pi(func_pi),
        .cut_pi(cut_pi0), .scan_en(scan_en0), .scan_in(scan_in0),
        .scan_out(scan_out), .cut_po(cut_po),
`ifdef BIST_DIAG_EN
        .bist_abort(bist_abort), .signature(signature0), .pat_cnt_o(pat_cnt0),
`endif
        .test_mode(test_mode0), .bist_end(bist_end0), .pass_fail(pass_fail0)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_pulse();
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; bist_start = 1'b1; func_pi = 3'b101; stuck = 1'b0;
        repeat (2) step();
        checks++; if (scan_en !== 1'b0) begin errors++; $display("FAIL reset_scan_en got=%b want=0", scan_en); end
        checks++; if (scan_in !== 1'b0) begin errors++; $display("FAIL reset_scan_in got=%b want=0", scan_in); end
        checks++; if (test_mode !== 1'b0) begin errors++; $display("FAIL reset_test_mode got=%b want=0", test_mode); end
        checks++; if (bist_end !== 1'b0) begin errors++; $display("FAIL reset_bist_end got=%b want=0", bist_end); end
        checks++; if (pass_fail !== 1'b0) begin errors++; $display("FAIL reset_pass_fail got=%b want=0", pass_fail); end
        checks++; if (cut_pi !== 3'b101) begin errors++; $display("FAIL reset_cut_pi got=%b want=101", cut_pi); end
        RST = 1'b0; bist_start = 1'b0;
        step();
        checks++; if (test_mode !== 1'b0) begin errors++; $display("FAIL idle_hold test_mode got=%b want=0", test_mode); end
    endtask

    task automatic test_session();
        func_pi = 3'b010;
        start_pulse();
        for (int n = 1; n <= 22; n++) begin
            checks++;
            if (test_mode !== (n >= 2 && n <= 20)) begin
                errors++; $display("FAIL session_test_mode cycle=%0d got=%b", n, test_mode);
            end
            checks++;
            if (scan_en !== (n >= 2 && n <= 20 && n != 6 && n != 11 && n != 16)) begin
                errors++; $display("FAIL session_scan_en cycle=%0d got=%b", n, scan_en);
            end
            if (n >= 2 && n <= 20 && n != 6 && n != 11 && n != 16) begin
                checks++;
                if (scan_in !== sin_tab[n][0]) begin
                    errors++; $display("FAIL session_scan_in cycle=%0d got=%b want=%0d", n, scan_in, sin_tab[n]);
                end
            end
            checks++;
            if (bist_end !== (n == 22)) begin
                errors++; $display("FAIL session_bist_end cycle=%0d got=%b", n, bist_end);
            end
            if (n == 6) begin
                checks++; if (cut_pi !== 3'b001) begin errors++; $display("FAIL capture1_cut_pi got=%b want=001", cut_pi); end
            end
            if (n == 11 || n == 16) begin
                checks++; if (cut_pi !== 3'b100) begin errors++; $display("FAIL capture_cut_pi cycle=%0d got=%b want=100", n, cut_pi); end
            end
            if (n == 1 || n == 22) begin
                checks++; if (cut_pi !== 3'b010) begin errors++; $display("FAIL func_cut_pi cycle=%0d got=%b want=010", n, cut_pi); end
            end
            if (n == 21) begin
                checks++; if (pass_fail !== 1'b0) begin errors++; $display("FAIL compare_pass_fail got=%b want=0", pass_fail); end
            end
            if (n == 22) begin
                checks++; if (pass_fail !== 1'b1) begin errors++; $display("FAIL session_pass_fail got=%b want=1", pass_fail); end
            end
`ifdef BIST_DIAG_EN
            if (n == 7) begin
                checks++; if (signature !== 16'h0003) begin errors++; $display("FAIL sig_after_capture1 got=%h want=0003", signature); end
                checks++; if (pat_cnt_o !== 2'd1) begin errors++; $display("FAIL pat_cnt_after_capture1 got=%0d want=1", pat_cnt_o); end
            end
            if (n == 22) begin
                checks++; if (signature !== 16'hC7A5) begin errors++; $display("FAIL final_signature got=%h want=c7a5", signature); end
                checks++; if (pat_cnt_o !== 2'd3) begin errors++; $display("FAIL final_pat_cnt got=%0d want=3", pat_cnt_o); end
            end
`endif
            if (n < 22) step();
        end
    endtask

    task automatic test_stuck_scan_out();
        stuck = 1'b1;
        start_pulse();
        repeat (20) step();
        checks++; if (bist_end !== 1'b0) begin errors++; $display("FAIL stuck_bist_end_early got=%b want=0", bist_end); end
        step();
        checks++; if (bist_end !== 1'b1) begin errors++; $display("FAIL stuck_bist_end got=%b want=1", bist_end); end
        checks++; if (pass_fail !== 1'b0) begin errors++; $display("FAIL stuck_pass_fail got=%b want=0", pass_fail); end
`ifdef BIST_DIAG_EN
        checks++; if (signature === 16'hC7A5) begin errors++; $display("FAIL stuck_signature got=%h want!=c7a5", signature); end
`endif
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid_session();
        func_pi = 3'b110;
        start_pulse();
        repeat (8) step();
        checks++; if (scan_en !== 1'b1) begin errors++; $display("FAIL mid_pre_scan_en got=%b want=1", scan_en); end
        RST = 1'b1;
        step();
        checks++; if (scan_en !== 1'b0) begin errors++; $display("FAIL mid_rst_scan_en got=%b want=0", scan_en); end
        checks++; if (scan_in !== 1'b0) begin errors++; $display("FAIL mid_rst_scan_in got=%b want=0", scan_in); end
        checks++; if (test_mode !== 1'b0) begin errors++; $display("FAIL mid_rst_test_mode got=%b want=0", test_mode); end
        checks++; if (bist_end !== 1'b0) begin errors++; $display("FAIL mid_rst_bist_end got=%b want=0", bist_end); end
        checks++; if (pass_fail !== 1'b0) begin errors++; $display("FAIL mid_rst_pass_fail got=%b want=0", pass_fail); end
        checks++; if (cut_pi !== 3'b110) begin errors++; $display("FAIL mid_rst_cut_pi got=%b want=110", cut_pi); end
        RST = 1'b0;
        step();
        start_pulse();
        repeat (20) step();
        checks++; if (bist_end !== 1'b0) begin errors++; $display("FAIL mid_rerun_bist_end_early got=%b want=0", bist_end); end
        step();
        checks++; if (bist_end !== 1'b1) begin errors++; $display("FAIL mid_rerun_bist_end got=%b want=1", bist_end); end
        checks++; if (pass_fail !== 1'b1) begin errors++; $display("FAIL mid_rerun_pass_fail got=%b want=1", pass_fail); end
    endtask

    task automatic test_start_held();
        bist_start = 1'b1;
        step();
        for (int n = 1; n <= 22; n++) begin
            checks++;
            if (test_mode !== (n >= 2 && n <= 20)) begin
                errors++; $display("FAIL held_test_mode cycle=%0d got=%b", n, test_mode);
            end
            checks++;
            if (bist_end !== (n == 22)) begin
                errors++; $display("FAIL held_bist_end cycle=%0d got=%b", n, bist_end);
            end
            if (n < 22) step();
        end
        checks++; if (pass_fail !== 1'b1) begin errors++; $display("FAIL held_pass_fail got=%b want=1", pass_fail); end
        step();
        checks++; if (bist_end !== 1'b0) begin errors++; $display("FAIL held_restart_bist_end got=%b want=0", bist_end); end
        checks++; if (pass_fail !== 1'b0) begin errors++; $display("FAIL held_restart_pass_fail got=%b want=0", pass_fail); end
        bist_start = 1'b0;
        repeat (20) step();
        checks++; if (bist_end !== 1'b0) begin errors++; $display("FAIL held_second_early got=%b want=0", bist_end); end
        step();
        checks++; if (bist_end !== 1'b1) begin errors++; $display("FAIL held_second_bist_end got=%b want=1", bist_end); end
        checks++; if (pass_fail !== 1'b1) begin errors++; $display("FAIL held_second_pass_fail got=%b want=1", pass_fail); end
        step();
        checks++; if (bist_end !== 1'b1) begin errors++; $display("FAIL done_hold_bist_end got=%b want=1", bist_end); end
    endtask

    task automatic test_seed_zero();
        int ones;
        ones = 0;
        start_pulse();
        for (int n = 1; n <= 22; n++) begin
            if ((n >= 2 && n <= 5) || (n >= 7 && n <= 10)) begin
                checks++;
                if (scan_in0 !== sin_tab[n][0]) begin
                    errors++; $display("FAIL seed0_scan_in cycle=%0d got=%b want=%0d", n, scan_in0, sin_tab[n]);
                end
                checks++;
                if (scan_en0 !== 1'b1) begin
                    errors++; $display("FAIL seed0_scan_en cycle=%0d got=%b want=1", n, scan_en0);
                end
                if (scan_in0 === 1'b1) ones++;
            end
            if (n == 6) begin
                checks++; if (cut_pi0 !== 3'b001) begin errors++; $display("FAIL seed0_cut_pi got=%b want=001", cut_pi0); end
                checks++; if (test_mode0 !== 1'b1) begin errors++; $display("FAIL seed0_test_mode got=%b want=1", test_mode0); end
            end
            if (n < 22) step();
        end
        checks++; if (ones == 0) begin errors++; $display("FAIL seed0_scan_in_constant ones=%0d want>0", ones); end
        checks++; if (bist_end0 !== 1'b1) begin errors++; $display("FAIL seed0_bist_end got=%b want=1", bist_end0); end
        checks++; if (pass_fail0 !== 1'b1) begin errors++; $display("FAIL seed0_pass_fail got=%b want=1", pass_fail0); end
`ifdef BIST_DIAG_EN
        checks++; if (signature0 !== 16'hC7A5) begin errors++; $display("FAIL seed0_signature got=%h want=c7a5", signature0); end
        checks++; if (pat_cnt0 !== 2'd3) begin errors++; $display("FAIL seed0_pat_cnt got=%0d want=3", pat_cnt0); end
`endif
    endtask

`ifdef BIST_DIAG_EN
    task automatic test_abort();
        start_pulse();
        repeat (3) step();
        bist_abort = 1'b1;
        step();
        bist_abort = 1'b0;
        checks++; if (bist_end !== 1'b1) begin errors++; $display("FAIL abort_bist_end got=%b want=1", bist_end); end
        checks++; if (pass_fail !== 1'b0) begin errors++; $display("FAIL abort_pass_fail got=%b want=0", pass_fail); end
        checks++; if (test_mode !== 1'b0) begin errors++; $display("FAIL abort_test_mode got=%b want=0", test_mode); end
    endtask
`endif

    initial begin
        sin_tab = '{1, 0, 0, 0, 0,  1, 1, 1, 0, 0,  0, 0, 1, 0, 0,  0, 0, 0, 0};
`ifdef BIST_DIAG_EN
        bist_abort = 1'b0;
`endif
        test_reset();
        test_session();
        test_stuck_scan_out();
        test_reset_mid_session();
        test_start_held();
        test_seed_zero();
`ifdef BIST_DIAG_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
